// File: rtl/ifsram_pkg.sv
// Shared definitions for the input-feature SRAM read engine: widths,
// convolution-size codes, kernel sizes and the read FSM state encoding.
package ifsram_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 11;
    localparam int NBUF   = 8;
    localparam int BEAT_W = 16;

    localparam logic [2:0] CONV_3X3 = 3'd2;
    localparam logic [2:0] CONV_5X5 = 3'd3;
    localparam logic [2:0] K_3X3    = 3'd3;
    localparam logic [2:0] K_5X5    = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_e;

    // Kernel edge length for a conv-switch code; 0 marks an unsupported code.
    function automatic logic [2:0] conv_k(input logic [2:0] sw);
        case (sw)
            CONV_3X3: return K_3X3;
            CONV_5X5: return K_5X5;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/count_yi_v4.sv
// Wrapping loop counter: counts 0..max_val on inc, wraps to 0 after max_val.
// at_max flags the final value so counters can be chained into nested loops.
module count_yi_v4
    import ifsram_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    assign at_max = (cnt == max_val);

    // Advance on inc, wrapping at max_val; clr restarts the loop.
    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= at_max ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/ifsram_rd.sv
// Input-feature SRAM read engine. Walks row r / column c / channel h for a
// KxK window, issues one-hot-low buffer reads, and streams the returned words
// through a 2-entry fall-through FIFO.
// Optional: define IFSRAM_RD_STALL_CNT_EN to build the output stall counter.
module ifsram_rd
    import ifsram_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              if_rd_start,
    output logic              if_rd_busy,
    output logic              if_rd_done,
    input  logic [4:0]        cfg_atlchin,
    input  logic [2:0]        cfg_conv_switch,
    input  logic [ADDR_W-1:0] cfg_row_base,
    input  logic [ADDR_W-1:0] cfg_row_pitch,
    output logic [NBUF-1:0]   rd_cen,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_rdata,
    output logic [DATA_W-1:0] ifo_data,
    output logic              ifo_valid,
    output logic              ifo_last,
    input  logic              ifo_ready,
    output logic [15:0]       ifo_stall_cnt
);

    rd_state_e state, state_nxt;
    logic start_acc, issue, last_rd;

    logic [2:0]        k_r;
    logic [4:0]        atl_r;
    logic              zero_r;
    logic [BEAT_W-1:0] beat_max_r;
    logic [ADDR_W-1:0] base_r, pitch_r;
    logic [BEAT_W-1:0] k_in, total_in;

    logic [4:0] h_cnt;
    logic [2:0] c_cnt, r_cnt;
    logic       h_max, c_max, r_max;

    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        fifo_cnt;
    logic              rd_vld_p1;
    logic              bypass, push, pop, accept;
    logic [BEAT_W-1:0] beat_cnt;

    assign start_acc = (state == ST_IDLE) && if_rd_start;
    assign k_in      = BEAT_W'(conv_k(cfg_conv_switch));
    assign total_in  = k_in * k_in * BEAT_W'(cfg_atlchin);

    // Latch loop bounds on an accepted start; later cfg changes are ignored.
    always_ff @(posedge clk) begin
        if (!reset) begin
            k_r        <= '0;
            atl_r      <= '0;
            zero_r     <= 1'b1;
            beat_max_r <= '0;
        end else if (start_acc) begin
            k_r        <= conv_k(cfg_conv_switch);
            atl_r      <= cfg_atlchin;
            zero_r     <= (conv_k(cfg_conv_switch) == 3'd0) || (cfg_atlchin == 5'd0);
            beat_max_r <= total_in - BEAT_W'(1);
        end
    end

    // Address operands only matter while issuing, so they carry no reset.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            base_r  <= cfg_row_base;
            pitch_r <= cfg_row_pitch;
        end
    end

    // Nested loops: channel innermost, then column, then row.
    count_yi_v4 #(.W(5)) u_cnt_h (
        .clk(clk), .reset(reset), .clr(start_acc), .inc(issue),
        .max_val(atl_r - 5'd1), .cnt(h_cnt), .at_max(h_max)
    );
    count_yi_v4 #(.W(3)) u_cnt_c (
        .clk(clk), .reset(reset), .clr(start_acc), .inc(issue && h_max),
        .max_val(k_r - 3'd1), .cnt(c_cnt), .at_max(c_max)
    );
    count_yi_v4 #(.W(3)) u_cnt_r (
        .clk(clk), .reset(reset), .clr(start_acc), .inc(issue && h_max && c_max),
        .max_val(k_r - 3'd1), .cnt(r_cnt), .at_max(r_max)
    );

    assign last_rd = h_max && c_max && r_max;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state and read issue; a read goes out only if its data is sure of a FIFO slot.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (if_rd_start) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (zero_r) begin
                    state_nxt = ST_DONE;
                end else if ((fifo_cnt + {1'b0, rd_vld_p1}) < 2'd2) begin
                    issue = 1'b1;
                    if (last_rd) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (accept && ifo_last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign if_rd_busy = (state != ST_IDLE);
    assign if_rd_done = (state == ST_DONE);
    assign rd_cen     = issue ? ~(NBUF'(1) << c_cnt) : '1;
    assign rd_addr    = issue ? (base_r + pitch_r * ADDR_W'(r_cnt) + ADDR_W'(h_cnt)) : '0;

    // Fall-through FIFO: returning data goes straight out when the FIFO is empty.
    assign ifo_valid = (fifo_cnt != 2'd0) || rd_vld_p1;
    assign ifo_data  = (fifo_cnt != 2'd0) ? fifo_mem[rd_ptr] : (rd_vld_p1 ? rd_rdata : '0);
    assign ifo_last  = ifo_valid && (beat_cnt == beat_max_r);
    assign accept    = ifo_valid && ifo_ready;
    assign bypass    = (fifo_cnt == 2'd0) && rd_vld_p1 && ifo_ready;
    assign push      = rd_vld_p1 && !bypass;
    assign pop       = (fifo_cnt != 2'd0) && ifo_ready;

    // FIFO control, read-return valid and output beat index.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_vld_p1 <= 1'b0;
            fifo_cnt  <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            rd_vld_p1 <= issue;
            fifo_cnt  <= fifo_cnt + 2'(push) - 2'(pop);
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            if (start_acc)   beat_cnt <= '0;
            else if (accept) beat_cnt <= beat_cnt + BEAT_W'(1);
        end
    end

    // FIFO storage; entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= rd_rdata;
    end

`ifdef IFSRAM_RD_STALL_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stall_cnt_r;

    // Count cycles where a beat is offered but refused, saturating.
    always_ff @(posedge clk) begin
        if (!reset)                      stall_cnt_r <= '0;
        else if (start_acc)              stall_cnt_r <= '0;
        else if (ifo_valid && !ifo_ready) stall_cnt_r <= sat_inc(stall_cnt_r);
    end

    assign ifo_stall_cnt = stall_cnt_r;
`else
    assign ifo_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifsram_rd.sv
// Directed table-driven bench for ifsram_rd with a 1-cycle-latency SRAM stub.
module tb_ifsram_rd;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_rd_start;
    logic        if_rd_busy, if_rd_done;
    logic [4:0]  cfg_atlchin;
    logic [2:0]  cfg_conv_switch;
    logic [10:0] cfg_row_base, cfg_row_pitch;
    logic [7:0]  rd_cen;
    logic [10:0] rd_addr;
    logic [63:0] rd_rdata = 64'h0;
    logic [63:0] ifo_data;
    logic        ifo_valid, ifo_last, ifo_ready;
    logic [15:0] ifo_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifsram_rd dut (
        .clk(clk), .reset(reset),
        .if_rd_start(if_rd_start), .if_rd_busy(if_rd_busy), .if_rd_done(if_rd_done),
        .cfg_atlchin(cfg_atlchin), .cfg_conv_switch(cfg_conv_switch),
        .cfg_row_base(cfg_row_base), .cfg_row_pitch(cfg_row_pitch),
        .rd_cen(rd_cen), .rd_addr(rd_addr), .rd_rdata(rd_rdata),
        .ifo_data(ifo_data), .ifo_valid(ifo_valid), .ifo_last(ifo_last),
        .ifo_ready(ifo_ready), .ifo_stall_cnt(ifo_stall_cnt)
    );

    // SRAM stub: word tags the buffer, address and read sequence number.
    int unsigned issue_total = 0;
    int unsigned seq_base    = 0;
    always @(posedge clk) begin
        if (rd_cen != 8'hFF) begin
            rd_rdata    <= {8'h5A, ~rd_cen, 5'd0, rd_addr, 32'(issue_total - seq_base)};
            issue_total <= issue_total + 1;
        end else begin
            rd_rdata <= {8'hEE, 24'h0, 32'(issue_total)};
        end
    end

    typedef struct {
        logic [2:0]  sw;
        logic [4:0]  atl;
        logic [10:0] base;
        logic [10:0] pitch;
        bit          toggle;
        int          n;
        logic [10:0] first_addr;
        logic [10:0] last_addr;
        logic [7:0]  last_cen;
        int          done_cyc;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cen"},   rd_cen, 8'hFF);
        chk({tag, "_addr"},  rd_addr, 11'd0);
        chk({tag, "_valid"}, ifo_valid, 1'b0);
        chk({tag, "_last"},  ifo_last, 1'b0);
        chk({tag, "_data"},  ifo_data, 64'd0);
        chk({tag, "_busy"},  if_rd_busy, 1'b0);
        chk({tag, "_done"},  if_rd_done, 1'b0);
        chk({tag, "_stall"}, ifo_stall_cnt, 16'd0);
    endtask

    task automatic run_case(input vec_t v);
        logic [10:0] ea[$];
        logic [7:0]  ec[$];
        logic [63:0] prev_data;
        logic [10:0] first_a, last_a;
        logic [7:0]  last_c;
        int k, n, iss, bts, cyc, first_vld, done_cyc, stall_exp;
        bit prev_stall;
        k = (v.sw == 3'd2) ? 3 : (v.sw == 3'd3) ? 5 : 0;
        for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++)
                for (int h = 0; h < int'(v.atl); h++) begin
                    ea.push_back(11'(int'(v.base) + r * int'(v.pitch) + h));
                    ec.push_back(~(8'(1) << c));
                end
        n = ea.size();
        iss = 0; bts = 0; first_vld = -1; done_cyc = -1; stall_exp = 0;
        prev_stall = 1'b0; prev_data = '0;
        first_a = '0; last_a = '0; last_c = 8'hFF;

        @(negedge clk);
        seq_base        = issue_total;
        cfg_conv_switch = v.sw;
        cfg_atlchin     = v.atl;
        cfg_row_base    = v.base;
        cfg_row_pitch   = v.pitch;
        ifo_ready       = 1'b1;
        if_rd_start     = 1'b1;

        for (cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk);
            if_rd_start     = (cyc == 5);
            cfg_conv_switch = 3'd3;
            cfg_atlchin     = 5'd7;
            cfg_row_base    = 11'd5;
            cfg_row_pitch   = 11'd9;
            ifo_ready       = v.toggle ? cyc[0] : 1'b1;
            #1;
            if (rd_cen !== 8'hFF) begin
                if (iss < n) begin
                    chk("issue_cen",  rd_cen,  ec[iss]);
                    chk("issue_addr", rd_addr, ea[iss]);
                end else begin
                    chk("extra_issue", iss, n);
                end
                chk("outstanding_lt2", (iss - bts) < 2, 1'b1);
                if (iss == 0) first_a = rd_addr;
                last_a = rd_addr;
                last_c = rd_cen;
                iss++;
            end
            if (prev_stall) begin
                chk("hold_valid", ifo_valid, 1'b1);
                chk("hold_data",  ifo_data,  prev_data);
            end
            if (ifo_valid) begin
                if (first_vld < 0) first_vld = cyc;
                if (ifo_ready) begin
                    if (bts < n) begin
                        chk("beat_data", ifo_data, {8'h5A, ~ec[bts], 5'd0, ea[bts], 32'(bts)});
                        chk("beat_last", ifo_last, bts == n - 1);
                    end else begin
                        chk("extra_beat", bts, n);
                    end
                    bts++;
                end else begin
                    stall_exp++;
                end
            end
            prev_stall = ifo_valid && !ifo_ready;
            prev_data  = ifo_data;
            if (if_rd_done) begin
                done_cyc = cyc;
                break;
            end
        end

        chk("done_seen", done_cyc >= 0, 1'b1);
        chk("issue_count", iss, v.n);
        chk("beat_count", bts, v.n);
`ifdef IFSRAM_RD_STALL_CNT_EN
        chk("stall_cnt", ifo_stall_cnt, stall_exp);
`else
        chk("stall_cnt", ifo_stall_cnt, 16'd0);
`endif
        if (v.n > 0) begin
            chk("first_addr", first_a, v.first_addr);
            chk("last_addr",  last_a,  v.last_addr);
            chk("last_cen",   last_c,  v.last_cen);
            chk("first_valid_cyc", first_vld, 2);
        end
        if (v.done_cyc >= 0) chk("done_cyc", done_cyc, v.done_cyc);

        // A start offered during the DONE cycle must not launch a run.
        if_rd_start = 1'b1;
        @(negedge clk);
        if_rd_start = 1'b0;
        #1;
        chk("post_done_busy", if_rd_busy, 1'b0);
        chk("post_done_done", if_rd_done, 1'b0);
        chk("post_done_cen",  rd_cen, 8'hFF);
    endtask

    initial begin
        vecs[0] = '{3'd2, 5'd4,  11'd44,   11'd12,  1'b0, 36,  11'd44,   11'd71,  8'hFB, 38};
        vecs[1] = '{3'd3, 5'd4,  11'd0,    11'd20,  1'b0, 100, 11'd0,    11'd83,  8'hEF, 102};
        vecs[2] = '{3'd2, 5'd3,  11'd100,  11'd7,   1'b1, 27,  11'd100,  11'd116, 8'hFB, -1};
        vecs[3] = '{3'd2, 5'd9,  11'd2040, 11'd12,  1'b0, 81,  11'd2040, 11'd24,  8'hFB, 83};
        vecs[4] = '{3'd1, 5'd4,  11'd10,   11'd10,  1'b0, 0,   11'd0,    11'd0,   8'hFF, 2};
        vecs[5] = '{3'd3, 5'd0,  11'd10,   11'd10,  1'b0, 0,   11'd0,    11'd0,   8'hFF, 2};
        vecs[6] = '{3'd3, 5'd2,  11'd300,  11'd50,  1'b1, 50,  11'd300,  11'd501, 8'hEF, -1};
        vecs[7] = '{3'd7, 5'd31, 11'd10,   11'd10,  1'b0, 0,   11'd0,    11'd0,   8'hFF, 2};
        vecs[8] = '{3'd3, 5'd31, 11'd1000, 11'd500, 1'b0, 775, 11'd1000, 11'd982, 8'hEF, 777};

        reset = 1'b0; if_rd_start = 1'b0; ifo_ready = 1'b1;
        cfg_atlchin = '0; cfg_conv_switch = '0; cfg_row_base = '0; cfg_row_pitch = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_idle("por");
        reset = 1'b1;

        for (int i = 0; i < 9; i++) run_case(vecs[i]);

        // Reset pulse mid-run right after beat 10 is accepted.
        @(negedge clk);
        seq_base = issue_total;
        cfg_conv_switch = 3'd2; cfg_atlchin = 5'd4; cfg_row_base = 11'd44; cfg_row_pitch = 11'd12;
        ifo_ready = 1'b1;
        if_rd_start = 1'b1;
        @(negedge clk);
        if_rd_start = 1'b0;
        repeat (11) @(negedge clk);
        #1;
        chk("pre_rst_busy", if_rd_busy, 1'b1);
        chk("pre_rst_beat", ifo_data[31:0], 32'd10);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_idle("rst_mid");
        @(negedge clk);
        #1;
        chk("rst_release_valid", ifo_valid, 1'b0);
        chk("rst_release_busy",  if_rd_busy, 1'b0);

        run_case(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
